// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, start/busy/done handshake.
// A single 2*XLEN register holds {hi, lo}: product accumulator, or {remainder, quotient}.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [TAG_W-1:0] rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FINISH} state_t;

    state_t              state_q;
    logic                busy_q, done_q;
    logic [XLEN-1:0]     result_q;
    logic [TAG_W-1:0]    rd_out_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [TAG_W-1:0]    tag_q;
    logic                neg_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [CW-1:0]       count_q;

    logic                sgn_a, sgn_b, neg_a, neg_b, b_zero, ovf, special, neg_d;
    logic [XLEN-1:0]     mag_a, mag_b, mcand_d;
    logic [2*XLEN-1:0]   prep_prod_d;

    // Operand conditioning, evaluated during PREP from the latched request
    always_comb begin
        sgn_a   = !((op_q == 3'b011) || (op_q[2] && op_q[0]));
        sgn_b   = op_q[2] ? !op_q[0] : !op_q[1];
        neg_a   = sgn_a && a_q[XLEN-1];
        neg_b   = sgn_b && b_q[XLEN-1];
        mag_a   = neg_a ? -a_q : a_q;
        mag_b   = neg_b ? -b_q : b_q;
        b_zero  = (b_q == '0);
        ovf     = op_q[2] && !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (&b_q);
        special = op_q[2] && (b_zero || ovf);
        neg_d   = (op_q[2] && op_q[1]) ? neg_a : (neg_a ^ neg_b);
        mcand_d = op_q[2] ? mag_b : mag_a;
        prep_prod_d = op_q[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
        if (special) begin
            // Preload final {rem, quo} so FINISH needs no special path
            neg_d       = 1'b0;
            prep_prod_d = b_zero ? {a_q, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_q};
        end
    end

    logic [XLEN:0]       sum, shifted;
    logic                fits;
    logic [XLEN-1:0]     div_rem;
    logic [2*XLEN-1:0]   prod_d;

    always_comb begin
        sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        shifted = prod_q[2*XLEN-1:XLEN-1];
        fits    = (shifted >= {1'b0, mcand_q});
        div_rem = shifted[XLEN-1:0] - mcand_q;
        prod_d  = op_q[2] ? {(fits ? div_rem : shifted[XLEN-1:0]), prod_q[XLEN-2:0], fits}
                          : {sum, prod_q[XLEN-1:1]};
    end

    logic [2*XLEN-1:0]   prod_sgn;
    logic [XLEN-1:0]     quo, rem, result_d;

    always_comb begin
        prod_sgn = neg_q ? -prod_q : prod_q;
        quo      = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem      = neg_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        if (op_q[2])
            result_d = op_q[1] ? rem : quo;
        else
            result_d = (op_q[1:0] == 2'b00) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !flush) begin
                            op_q    <= op;
                            a_q     <= a;
                            b_q     <= b;
                            tag_q   <= rd_in;
                            busy_q  <= 1'b1;
                            state_q <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        neg_q   <= neg_d;
                        mcand_q <= mcand_d;
                        prod_q  <= prep_prod_d;
                        count_q <= CW'(XLEN-1);
                        state_q <= special ? S_FINISH : S_RUN;
                    end
                    S_RUN: begin
                        prod_q <= prod_d;
                        if (count_q == '0)
                            state_q <= S_FINISH;
                        else
                            count_q <= count_q - 1'b1;
                    end
                    default: begin
                        result_q <= result_d;
                        rd_out_q <= tag_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
endmodule
